wb_arbiter: RTL and testbench

//   Writeback stage feeding the 16x32 register file's single write port (we/rd/wd).

---
 rtl/wb_arbiter_if.sv | 26 ++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU and load-unit result handshakes in, regfile write port
// and pending mask out. The arbiter takes the slave side.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        we;
  logic [3:0]  rd;
  logic [31:0] wd;
  logic [15:0] pending;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, we, rd, wd, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, we, rd, wd, pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs (ALU, load) round-robin merged onto one registered
// regfile write port. Optional per-register pending mask enabled by WB_PENDING_EN.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ALU   = 0;
  localparam int MEM   = 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {LAST_ALU, LAST_MEM} rr_state_e;

  entry_t           fifo_mem [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr   [2];
  logic [PTR_W-1:0] rd_ptr   [2];
  logic [PTR_W:0]   count    [2];
  entry_t           in_entry [2];
  entry_t           head     [2];
  logic [1:0]       full, nonempty, push, pop;
  entry_t           gnt;
  logic             gnt_valid;
  rr_state_e        state_q, state_d;

  assign in_entry[ALU] = '{rd: bus.alu_rd, data: bus.alu_data};
  assign in_entry[MEM] = '{rd: bus.mem_rd, data: bus.mem_data};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      full[s]     = (count[s] == FULL_CNT);
      nonempty[s] = (count[s] != '0);
      head[s]     = fifo_mem[s][rd_ptr[s]];
    end
  end

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign bus.alu_ready = !rst && !full[ALU];
  assign bus.mem_ready = !rst && !full[MEM];
  assign push = {bus.mem_valid && bus.mem_ready, bus.alu_valid && bus.alu_ready};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state_q <= LAST_MEM;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a missed branch would
    // otherwise infer a latch.
    state_d = state_q;
    pop     = '0;
    unique case (state_q)
      LAST_MEM: begin
        if (nonempty[ALU]) begin
          pop[ALU] = 1'b1;
          state_d  = LAST_ALU;
        end else if (nonempty[MEM]) begin
          pop[MEM] = 1'b1;
        end
      end
      LAST_ALU: begin
        if (nonempty[MEM]) begin
          pop[MEM] = 1'b1;
          state_d  = LAST_MEM;
        end else if (nonempty[ALU]) begin
          pop[ALU] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt       = pop[MEM] ? head[MEM] : head[ALU];
  assign gnt_valid = |pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        count[s] <= count[s] + (PTR_W+1)'(push[s]) - (PTR_W+1)'(pop[s]);
      end
    end
  end

  // NOTE: storage has no reset; entries are only observed through count, which does.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) fifo_mem[s][wr_ptr[s]] <= in_entry[s];
    end
  end

  // Writes to r0 still consume the grant but never reach the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.we <= 1'b0;
      bus.rd <= '0;
      bus.wd <= '0;
    end else begin
      bus.we <= gnt_valid && (gnt.rd != 4'd0);
      if (gnt_valid) begin
        bus.rd <= gnt.rd;
        bus.wd <= gnt.data;
      end
    end
  end

`ifdef WB_PENDING_EN
  logic [15:0] pending_mask;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending_mask = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((PTR_W+1)'(PTR_W'(i) - rd_ptr[s]) < count[s])
          pending_mask[fifo_mem[s][i].rd] = 1'b1;
      end
    end
    if (bus.we) pending_mask[bus.rd] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign bus.pending = pending_mask;
`else
  assign bus.pending = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a transaction-level model feeds a scoreboard of
// expected regfile writes, plus directed scenarios for latency, ordering and reset.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
`ifdef WB_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus();
  wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  ent_t aq[$], mq[$], exp_q[$], wr_log[$];
  ent_t alu_stim[$], mem_stim[$];
  bit   m_last_mem = 1'b1;
  bit   m_we       = 1'b0;
  logic [3:0] m_rd = 4'd0;
  bit   mon_en     = 1'b0;
  bit   we_seen    = 1'b0;

  ent_t m_g;
  bit   m_gv, m_acc_a, m_acc_m;

  // Reference model: arbitration on pre-edge queue heads, then accepted pushes.
  always @(posedge clk) begin
    m_acc_a = bus.alu_valid && !rst && (aq.size() < DEPTH);
    m_acc_m = bus.mem_valid && !rst && (mq.size() < DEPTH);
    if (rst) begin
      aq.delete();
      mq.delete();
      m_last_mem = 1'b1;
      m_we       = 1'b0;
      m_rd       = 4'd0;
    end else begin
      m_gv = 1'b0;
      if (aq.size() > 0 && (mq.size() == 0 || m_last_mem)) begin
        m_g = aq.pop_front(); m_gv = 1'b1; m_last_mem = 1'b0;
      end else if (mq.size() > 0) begin
        m_g = mq.pop_front(); m_gv = 1'b1; m_last_mem = 1'b1;
      end
      m_we = m_gv && (m_g.rd != 4'd0);
      if (m_gv) m_rd = m_g.rd;
      if (m_we) exp_q.push_back(m_g);
      if (m_acc_a) aq.push_back('{rd: bus.alu_rd, data: bus.alu_data});
      if (m_acc_m) mq.push_back('{rd: bus.mem_rd, data: bus.mem_data});
    end
  end

  function automatic logic [15:0] model_pending();
    logic [15:0] p = '0;
    if (PEND_EN) begin
      foreach (aq[i]) p[aq[i].rd] = 1'b1;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      if (m_we) p[m_rd] = 1'b1;
      p[0] = 1'b0;
    end
    return p;
  endfunction

  ent_t mon_e;
  logic exp_ar, exp_mr;
  logic [15:0] exp_p;

  // Scoreboard: every cycle compare the write port, readies and pending mask.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (bus.we !== m_we) begin
        miscompares++;
        $display("FAIL sb_we t=%0t got %b want %b", $time, bus.we, m_we);
      end
      if (bus.we === 1'b1) begin
        we_seen = 1'b1;
        wr_log.push_back('{rd: bus.rd, data: bus.wd});
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_write t=%0t got rd=%0d wd=%h want no write", $time, bus.rd, bus.wd);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.rd !== mon_e.rd || bus.wd !== mon_e.data) begin
            miscompares++;
            $display("FAIL sb_write t=%0t got rd=%0d wd=%h want rd=%0d wd=%h",
                     $time, bus.rd, bus.wd, mon_e.rd, mon_e.data);
          end
        end
      end
      exp_ar = !rst && (aq.size() < DEPTH);
      exp_mr = !rst && (mq.size() < DEPTH);
      exp_p  = model_pending();
      vectors++;
      if (bus.alu_ready !== exp_ar || bus.mem_ready !== exp_mr) begin
        miscompares++;
        $display("FAIL sb_ready t=%0t got alu=%b mem=%b want alu=%b mem=%b",
                 $time, bus.alu_ready, bus.mem_ready, exp_ar, exp_mr);
      end
      vectors++;
      if (bus.pending !== exp_p) begin
        miscompares++;
        $display("FAIL sb_pending t=%0t got %h want %h", $time, bus.pending, exp_p);
      end
    end
  end

  task automatic drive_alu(output int refused);
    int budget = 200;
    bit acc;
    refused = 0;
    while (alu_stim.size() > 0 && budget > 0) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = alu_stim[0].rd;
      bus.alu_data  = alu_stim[0].data;
      @(negedge clk);
      acc = bus.alu_ready;
      if (!acc) refused++;
      @(posedge clk); #1;
      if (acc) void'(alu_stim.pop_front());
      budget--;
    end
    bus.alu_valid = 1'b0;
    vectors++;
    if (alu_stim.size() != 0) begin
      miscompares++;
      $display("FAIL alu_drive_timeout got %0d left want 0", alu_stim.size());
    end
  endtask

  task automatic drive_mem(output int refused);
    int budget = 200;
    bit acc;
    refused = 0;
    while (mem_stim.size() > 0 && budget > 0) begin
      bus.mem_valid = 1'b1;
      bus.mem_rd    = mem_stim[0].rd;
      bus.mem_data  = mem_stim[0].data;
      @(negedge clk);
      acc = bus.mem_ready;
      if (!acc) refused++;
      @(posedge clk); #1;
      if (acc) void'(mem_stim.pop_front());
      budget--;
    end
    bus.mem_valid = 1'b0;
    vectors++;
    if (mem_stim.size() != 0) begin
      miscompares++;
      $display("FAIL mem_drive_timeout got %0d left want 0", mem_stim.size());
    end
  endtask

  task automatic drain();
    int n = 0;
    while (n < 50 && (aq.size() != 0 || mq.size() != 0 || exp_q.size() != 0 || m_we)) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d writes outstanding want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_low got alu=%b mem=%b want 0 0", bus.alu_ready, bus.mem_ready);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.we !== 1'b0 || bus.pending !== 16'h0000 || bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state got we=%b pend=%h ar=%b mr=%b want 0 0000 1 1",
               bus.we, bus.pending, bus.alu_ready, bus.mem_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd5; bus.alu_data = 32'hDEADBEEF;
    @(posedge clk); #1;  // E0
    bus.alu_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.we !== 1'b0) begin
      miscompares++; $display("FAIL single_e0 got we=%b want 0", bus.we);
    end
    @(negedge clk);      // after E1
    vectors++;
    if (bus.we !== 1'b1 || bus.rd !== 4'd5 || bus.wd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_e1 got we=%b rd=%0d wd=%h want 1 5 deadbeef", bus.we, bus.rd, bus.wd);
    end
    @(negedge clk);      // after E2
    vectors++;
    if (bus.we !== 1'b0) begin
      miscompares++; $display("FAIL single_e2 got we=%b want 0", bus.we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int ra, rm;
    logic [3:0] want [6] = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      alu_stim.push_back('{rd: 4'(i + 1), data: 32'hA100_0000 + i});
      mem_stim.push_back('{rd: 4'(i + 9), data: 32'hB100_0000 + i});
    end
    fork
      drive_alu(ra);
      drive_mem(rm);
    join
    drain();
    vectors++;
    if (wr_log.size() != 6) begin
      miscompares++;
      $display("FAIL contention_count got %0d want 6", wr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (wr_log[i].rd !== want[i]) begin
          miscompares++;
          $display("FAIL contention_order[%0d] got rd=%0d want rd=%0d", i, wr_log[i].rd, want[i]);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    int ra, rm, k;
    wr_log.delete();
    for (int i = 0; i < 10; i++)
      alu_stim.push_back('{rd: 4'((i % 7) + 1), data: 32'hAA00_0000 + i});
    for (int i = 0; i < 6; i++)
      mem_stim.push_back('{rd: 4'(8 + i), data: 32'hBB00_0000 + i});
    fork
      drive_alu(ra);
      drive_mem(rm);
    join
    drain();
    vectors++;
    if (rm == 0) begin
      miscompares++; $display("FAIL bp_mem_ready_drop got refusals=%0d want >0", rm);
    end
    k = 0;
    foreach (wr_log[i]) begin
      if (wr_log[i].data[31:24] == 8'hBB) begin
        vectors++;
        if (wr_log[i].data !== 32'hBB00_0000 + k || wr_log[i].rd !== 4'(8 + k)) begin
          miscompares++;
          $display("FAIL bp_mem_order[%0d] got rd=%0d wd=%h want rd=%0d wd=%h",
                   k, wr_log[i].rd, wr_log[i].data, 8 + k, 32'hBB00_0000 + k);
        end
        k++;
      end
    end
    vectors++;
    if (k != 6) begin
      miscompares++; $display("FAIL bp_mem_count got %0d want 6", k);
    end
  endtask

  task automatic test_r0_pending();
    we_seen = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd0; bus.alu_data = 32'h1234;
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (we_seen) begin
      miscompares++; $display("FAIL r0_drop got we=1 seen want never");
    end
    @(posedge clk); #1;
    bus.mem_valid = 1'b1; bus.mem_rd = 4'd7; bus.mem_data = 32'h7777_0007;
    @(posedge clk); #1;  // E0
    bus.mem_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.pending[7] !== PEND_EN) begin
      miscompares++; $display("FAIL pend7_e0 got %b want %b", bus.pending[7], PEND_EN);
    end
    @(negedge clk);      // after E1
    vectors++;
    if (bus.pending[7] !== PEND_EN || bus.we !== 1'b1 || bus.rd !== 4'd7) begin
      miscompares++;
      $display("FAIL pend7_e1 got pend=%b we=%b rd=%0d want %b 1 7", bus.pending[7], bus.we, bus.rd, PEND_EN);
    end
    @(negedge clk);      // after E2
    vectors++;
    if (bus.pending[7] !== 1'b0 || bus.we !== 1'b0) begin
      miscompares++;
      $display("FAIL pend7_e2 got pend=%b we=%b want 0 0", bus.pending[7], bus.we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 4'(i + 1); bus.alu_data = 32'hC000_0000 + i;
      bus.mem_valid = 1'b1; bus.mem_rd = 4'(i + 8); bus.mem_data = 32'hD000_0000 + i;
      @(posedge clk); #1;
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.we !== 1'b0 || bus.pending !== 16'h0000) begin
        miscompares++;
        $display("FAIL midop_reset[%0d] got we=%b pend=%h want 0 0000", i, bus.we, bus.pending);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    test_reset();
    test_single_alu();
    test_contention();
    test_back_pressure();
    test_r0_pending();
    test_midop_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL final_outstanding got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
